// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a 1-entry holding register.
//
// A byte is accepted on any rising clk where din_valid and din_ready are
// both high. It waits in the holding register until the serialiser is free,
// then is sent as: one start bit (0), eight data bits (MSB or LSB first),
// and STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk        single clock, all logic on its rising edge
//   rst_n      synchronous active-low reset
//   din        byte offered for transmission
//   din_valid  din holds a byte to send
//   din_ready  holding register is empty; a byte can be accepted this cycle
//   tx         serial line, idle high, registered
//   busy       frame in progress or byte waiting (registered)
//   done       one-cycle pulse on the last cycle of each frame's final stop bit
//
// Output timing: tx, done and busy are registered from the current FSM state,
// so the line lags the state register by one clock. A byte accepted while
// idle therefore shows its start bit two clocks after the accept edge
// (holding-register load, then START), and done lines up with the last stop
// cycle actually visible on tx.
module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // Wide enough to count a full two-stop-bit period in a single run.
  localparam int CNT_W = $clog2(CLKS_PER_BIT * 2 + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [2:0]       idx;
  logic [2:0]       idx_n;
  logic             hold_full;
  logic             hold_full_n;
  logic [7:0]       hold;
  logic [7:0]       shreg;
  logic             tx_n;
  logic             done_n;
  logic             load;
  logic             accept;

  // Data bit currently on the line, honouring the configured bit order.
  function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i);
    logic r;
    if (MSB_FIRST != 0) begin
      r = b[3'd7 - i];
    end else begin
      r = b[i];
    end
    return r;
  endfunction

  assign accept = din_valid & din_ready;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    hold_full_n = hold_full;
    tx_n        = 1'b1;
    done_n      = 1'b0;
    load        = 1'b0;

    unique case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = START;
          cnt_n   = '0;
        end
      end

      START: begin
        tx_n = 1'b0;
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          idx_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        tx_n = pick_bit(shreg, idx);
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        // All stop bits are timed as one continuous period.
        if (cnt == STOP_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          if (hold_full) begin
            // Chain straight into the next start bit, no idle gap.
            load    = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (load) begin
      hold_full_n = 1'b0;
    end
    // accept and load never coincide: din_ready is low whenever the
    // holding register is full, which load requires.
    if (accept) begin
      hold_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= 3'd0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      done      <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      hold_full <= hold_full_n;
      tx        <= tx_n;
      done      <= done_n;
      busy      <= (state != IDLE) | hold_full;
      // Registered so it stays low through reset and reflects the
      // holding register from the first clock after release.
      din_ready <= ~hold_full_n;
    end
  end

  // Byte storage carries no reset; validity is tracked by hold_full/state.
  always_ff @(posedge clk) begin
    if (load) begin
      shreg <= hold;
    end
    if (accept) begin
      hold <= din;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din_a [3];
  logic [2:0] val_a;
  logic [2:0] rdy_a;
  logic [2:0] tx_a;
  logic [2:0] busy_a;
  logic [2:0] done_a;

  int n_chk;
  int n_fail;

  logic       lb_on;
  int         rx_frames;
  logic [7:0] exp_q [$];

  uart_tx #(.CLKS_PER_BIT(1), .MSB_FIRST(1), .STOP_BITS(1)) u_def (
    .clk(clk), .rst_n(rst_n), .din(din_a[0]), .din_valid(val_a[0]),
    .din_ready(rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0])
  );

  uart_tx #(.CLKS_PER_BIT(4), .MSB_FIRST(0), .STOP_BITS(1)) u_lsb4 (
    .clk(clk), .rst_n(rst_n), .din(din_a[1]), .din_valid(val_a[1]),
    .din_ready(rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1])
  );

  uart_tx #(.CLKS_PER_BIT(3), .MSB_FIRST(1), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .din(din_a[2]), .din_valid(val_a[2]),
    .din_ready(rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte for a single cycle; the following edge is the accept edge.
  task automatic offer(input int which, input logic [7:0] b);
    din_a[which] = b;
    val_a[which] = 1'b1;
    tick();
    val_a[which] = 1'b0;
  endtask

  // Record n consecutive post-edge samples; the first sample lands in the MSB.
  task automatic capture(input int which, input int n,
                         output logic [63:0] txv, output logic [63:0] donev,
                         output logic [63:0] busyv, output logic [63:0] rdyv);
    txv = '0; donev = '0; busyv = '0; rdyv = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      txv   = {txv[62:0], tx_a[which]};
      donev = {donev[62:0], done_a[which]};
      busyv = {busyv[62:0], busy_a[which]};
      rdyv  = {rdyv[62:0], rdy_a[which]};
    end
  endtask

  // Reference receiver: one sample per clock, start 0, 8 bits MSB first, stop 1.
  initial begin
    logic       act;
    int         cnt;
    logic [7:0] sh;
    act = 1'b0;
    cnt = 0;
    sh  = '0;
    rx_frames = 0;
    forever begin
      @(negedge clk);
      if (!lb_on || !rst_n) begin
        act = 1'b0;
      end else if (!act) begin
        if (tx_a[0] == 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else if (cnt < 8) begin
        sh  = {sh[6:0], tx_a[0]};
        cnt = cnt + 1;
      end else begin
        act = 1'b0;
        rx_frames++;
        chk("lb_stop", {63'd0, tx_a[0]}, 64'd1);
        if (exp_q.size() == 0) begin
          chk("lb_extra_frame", 64'd1, 64'd0);
        end else begin
          chk("lb_data", {56'd0, sh}, {56'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    logic [63:0] txv, donev, busyv, rdyv;
    logic        first_tx, first_done, first_rdy;
    logic [7:0]  b;
    int          w;

    n_chk = 0;
    n_fail = 0;
    lb_on = 1'b0;
    val_a = '0;
    for (int i = 0; i < 3; i++) din_a[i] = 8'h00;

    // Reset behaviour
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_tx", {61'd0, tx_a}, 64'h7);
    chk("rst_ready", {61'd0, rdy_a}, 64'h0);
    chk("rst_busy", {61'd0, busy_a}, 64'h0);
    chk("rst_done", {61'd0, done_a}, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {61'd0, rdy_a}, 64'h7);

    // Defaults, 0xA5
    offer(0, 8'hA5);
    tick();
    chk("a5_latency_tx", {63'd0, tx_a[0]}, 64'd1);
    capture(0, 10, txv, donev, busyv, rdyv);
    chk("a5_tx", txv, 64'b0101001011);
    chk("a5_done", donev, 64'b0000000001);
    chk("a5_busy", busyv, 64'b1111111111);
    tick();
    chk("a5_busy_after", {63'd0, busy_a[0]}, 64'd0);
    chk("a5_done_after", {63'd0, done_a[0]}, 64'd0);

    // CLKS_PER_BIT=4, LSB first, 0x01
    offer(1, 8'h01);
    tick();
    chk("x01_latency_tx", {63'd0, tx_a[1]}, 64'd1);
    capture(1, 40, txv, donev, busyv, rdyv);
    chk("x01_tx", txv, 64'h0F_0000_000F);
    chk("x01_done", donev, 64'd1);
    tick();
    chk("x01_tx_idle", {63'd0, tx_a[1]}, 64'd1);
    chk("x01_done_after", {63'd0, done_a[1]}, 64'd0);

    // STOP_BITS=2, CLKS_PER_BIT=3, 0xFF
    offer(2, 8'hFF);
    tick();
    capture(2, 33, txv, donev, busyv, rdyv);
    chk("xff_tx", txv, 64'h0_3FFF_FFFF);
    chk("xff_done", donev, 64'd1);
    chk("xff_busy", busyv, 64'h1_FFFF_FFFF);
    tick();
    chk("xff_busy_after", {63'd0, busy_a[2]}, 64'd0);

    // Back-to-back 0x3C, 0xC3 with din_valid held high
    din_a[0] = 8'h3C;
    val_a[0] = 1'b1;
    tick();
    chk("b2b_ready_after_accept", {63'd0, rdy_a[0]}, 64'd0);
    din_a[0] = 8'hC3;
    tick();
    chk("b2b_ready_after_load", {63'd0, rdy_a[0]}, 64'd1);
    chk("b2b_tx_pre", {63'd0, tx_a[0]}, 64'd1);
    tick();
    val_a[0] = 1'b0;
    first_tx   = tx_a[0];
    first_done = done_a[0];
    first_rdy  = rdy_a[0];
    capture(0, 19, txv, donev, busyv, rdyv);
    chk("b2b_tx", {44'd0, first_tx, txv[18:0]}, 64'b0001111001_0110000111);
    chk("b2b_done", {44'd0, first_done, donev[18:0]}, 64'b0000000001_0000000001);
    chk("b2b_ready", {44'd0, first_rdy, rdyv[18:0]}, 64'b0000_0000_0111_1111_1111);
    tick();
    chk("b2b_tx_idle", {63'd0, tx_a[0]}, 64'd1);
    chk("b2b_busy_after", {63'd0, busy_a[0]}, 64'd0);

    // Reset during data bit 4 of 0x55 with 0xAA waiting
    din_a[0] = 8'h55;
    val_a[0] = 1'b1;
    tick();
    din_a[0] = 8'hAA;
    tick();
    tick();
    val_a[0] = 1'b0;
    chk("rst55_aa_held", {63'd0, rdy_a[0]}, 64'd0);
    first_tx = tx_a[0];
    capture(0, 4, txv, donev, busyv, rdyv);
    chk("rst55_tx_head", {59'd0, first_tx, txv[3:0]}, 64'b00101);
    rst_n = 1'b0;
    tick();
    chk("rst55_tx", {63'd0, tx_a[0]}, 64'd1);
    chk("rst55_ready", {63'd0, rdy_a[0]}, 64'd0);
    chk("rst55_done", {63'd0, done_a[0]}, 64'd0);
    chk("rst55_busy", {63'd0, busy_a[0]}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst55_ready_release", {63'd0, rdy_a[0]}, 64'd1);
    capture(0, 30, txv, donev, busyv, rdyv);
    chk("rst55_tx_quiet", txv, 64'h3FFF_FFFF);
    chk("rst55_no_done", donev, 64'd0);
    chk("rst55_busy_quiet", busyv, 64'd0);

    // Loopback of 256 random bytes into the reference receiver
    lb_on = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (!rdy_a[0] && w < 50) begin
        tick();
        w++;
      end
      if (w >= 50) begin
        chk("lb_ready_timeout", 64'd0, 64'd1);
      end
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      offer(0, b);
    end
    for (int i = 0; i < 40; i++) tick();
    chk("lb_frames", rx_frames, 64'd256);
    chk("lb_queue_empty", exp_q.size(), 64'd0);
    lb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
